// File: rtl/mux_n_rr_reg_pkg.sv
// Shared constants for the registered N-channel selector.
// Mode encoding is shared between the top level and its users.
package mux_n_rr_reg_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/mux_n_rr_reg_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after ptr, wrapping
// back around to ptr itself, found with a masked search over a doubled vector.
module rr_arbiter
  import mux_n_rr_reg_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  logic [2*NCH-1:0] dreq;
  logic [2*NCH-1:0] win_mask;
  logic [2*NCH-1:0] masked;

  assign dreq = {req, req};

  // The window ptr+1 .. ptr+NCH covers every channel exactly once.
  genvar gi;
  generate
    for (gi = 0; gi < 2*NCH; gi++) begin : g_mask
      assign win_mask[gi] = (gi > int'(ptr)) && (gi <= int'(ptr) + NCH);
    end
  endgenerate

  assign masked = dreq & win_mask;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int p = 2*NCH-1; p >= 0; p--) begin
      if (masked[p]) begin
        gnt_valid = 1'b1;
        gnt_idx   = (p >= NCH) ? SELW'(p - NCH) : SELW'(p);
      end
    end
  end

endmodule

// File: rtl/mux_n_rr_reg.sv
// Registered N-channel selector with per-channel valid/ready handshake, choosing
// a channel by explicit select or round-robin and holding it in a one-deep output.
module mux_n_rr_reg
  import mux_n_rr_reg_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] ch_data [NCH];
  logic [NCH-1:0]   sel_hit;
  logic [NCH-1:0]   chan_oh;

  logic             load;
  logic             grant;
  logic [SELW-1:0]  chan;
  logic             rr_gnt_valid;
  logic [SELW-1:0]  rr_gnt_idx;
  logic [WIDTH-1:0] sel_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  // An out-of-range sel matches no channel, so it can never produce a grant.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign sel_hit[gi]  = in_valid[gi] & (sel == SELW'(gi));
      assign chan_oh[gi]  = (chan == SELW'(gi));
      assign in_ready[gi] = reset_n & load & grant & chan_oh[gi];
    end
  endgenerate

  assign load  = ~out_valid_q | out_ready;
  assign chan  = (mode == MODE_RR) ? rr_gnt_idx : sel;
  assign grant = (mode == MODE_RR) ? rr_gnt_valid : |sel_hit;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chan_oh[i]) begin
        sel_data = ch_data[i];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_ch_d    = chan;
        ptr_d       = chan;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // ptr resets to the last channel so channel 0 wins the first RR search.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_rr_reg.sv
// Drives a 4-channel and a 3-channel selector with shared stimulus and compares
// both against a channel-level reference model of the grant and output register.
module tb_mux_n_rr_reg;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         mode;
  logic [1:0]   sel;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic         out_ready;

  logic [3:0]   in_ready4;
  logic [31:0]  out_data4;
  logic [1:0]   out_ch4;
  logic         out_valid4;

  logic [2:0]   in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_ch3;
  logic         out_valid3;

  always #5 clock = ~clock;

  mux_n_rr_reg #(.WIDTH(32), .NCH(4)) u_dut4 (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_ch    (out_ch4),
    .out_valid (out_valid4),
    .out_ready (out_ready)
  );

  mux_n_rr_reg #(.WIDTH(32), .NCH(3)) u_dut3 (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data[95:0]),
    .in_valid  (in_valid[2:0]),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready)
  );

  // Reference state per instance: index 0 is the 4-channel DUT, 1 the 3-channel.
  bit          m_valid [2];
  logic [31:0] m_data  [2];
  int          m_ch    [2];
  int          m_ptr   [2];
  bit          m_known = 1'b0;

  int nchecks = 0;
  int nerrors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns the granted channel, or -1 when nothing is granted.
  function automatic int ref_grant(input int n, input bit md, input int s,
                                   input logic [3:0] v, input int p);
    if (md == 1'b0) begin
      if (s < n && v[s]) return s;
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (p + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input bit rn, input bit md, input int s, input logic [3:0] v,
                      input bit ordy, input logic [127:0] d);
    int         g  [2];
    bit         ld [2];
    int         n;
    logic [3:0] exp_rdy;
    logic [3:0] act_rdy;
    @(negedge clock);
    reset_n   = rn;
    mode      = md;
    sel       = 2'(s);
    in_valid  = v;
    out_ready = ordy;
    in_data   = d;
    #1;
    for (int u = 0; u < 2; u++) begin
      n     = (u == 0) ? 4 : 3;
      ld[u] = !m_valid[u] || ordy;
      g[u]  = ref_grant(n, md, s, (u == 0) ? v : {1'b0, v[2:0]}, m_ptr[u]);
      if (m_known) begin
        exp_rdy = (rn && ld[u] && g[u] >= 0) ? 4'(1 << g[u]) : 4'b0;
        act_rdy = (u == 0) ? in_ready4 : {1'b0, in_ready3};
        check($sformatf("in_ready_n%0d", n), 32'(act_rdy), 32'(exp_rdy));
        check($sformatf("out_valid_n%0d", n), 32'((u == 0) ? out_valid4 : out_valid3),
              32'(m_valid[u]));
        if (m_valid[u]) begin
          check($sformatf("out_data_n%0d", n), (u == 0) ? out_data4 : out_data3, m_data[u]);
          check($sformatf("out_ch_n%0d", n), 32'((u == 0) ? out_ch4 : out_ch3), 32'(m_ch[u]));
        end
      end
    end
    @(posedge clock);
    for (int u = 0; u < 2; u++) begin
      n = (u == 0) ? 4 : 3;
      if (!rn) begin
        m_valid[u] = 1'b0;
        m_data[u]  = '0;
        m_ch[u]    = 0;
        m_ptr[u]   = n - 1;
      end else if (ld[u]) begin
        if (g[u] >= 0) begin
          m_valid[u] = 1'b1;
          m_data[u]  = d[g[u]*32 +: 32];
          m_ch[u]    = g[u];
          m_ptr[u]   = g[u];
          $display("xfer n=%0d mode=%0d ch=%0d data=%h", n, md, g[u], m_data[u]);
        end else begin
          m_valid[u] = 1'b0;
        end
      end
    end
    if (!rn) m_known = 1'b1;
  endtask

  logic [127:0] d_rr;
  logic [127:0] d_bb;
  logic [127:0] d_rnd;

  initial begin
    reset_n   = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    d_rr = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    d_bb = {32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333, 32'h4444_4444};

    step(1'b0, 1'b0, 0, 4'b0000, 1'b0, d_rr);
    step(1'b0, 1'b0, 0, 4'b0000, 1'b0, d_rr);
    #1;
    check("reset_valid", 32'(out_valid4), 32'd0);
    check("reset_data", out_data4, 32'd0);

    // Round-robin across all channels from reset: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 0, 4'b1111, 1'b1, d_rr);
      #1;
      check("rr_seq_ch", 32'(out_ch4), 32'(i % 4));
      check("rr_seq_data", out_data4, 32'hA000_0000 + 32'(i % 4));
    end

    // Explicit select, then a select whose channel is idle.
    step(1'b1, 1'b0, 2, 4'b0100, 1'b1, d_bb);
    #1;
    check("sel2_data", out_data4, 32'hDEAD_BEEF);
    check("sel2_ch", 32'(out_ch4), 32'd2);
    step(1'b1, 1'b0, 2, 4'b1011, 1'b1, d_bb);
    #1;
    check("sel2_idle_valid", 32'(out_valid4), 32'd0);

    // Backpressure for three cycles, then release.
    step(1'b1, 1'b1, 0, 4'b1111, 1'b1, d_rr);
    repeat (3) step(1'b1, 1'b1, 0, 4'b1111, 1'b0, d_bb);
    step(1'b1, 1'b1, 0, 4'b1111, 1'b1, d_bb);

    // Mode switch continues round-robin after the explicit winner.
    step(1'b1, 1'b0, 1, 4'b0010, 1'b1, d_rr);
    step(1'b1, 1'b1, 0, 4'b1111, 1'b1, d_rr);
    #1;
    check("mode_switch_ch", 32'(out_ch4), 32'd2);

    // Reset while a word is held.
    step(1'b0, 1'b1, 0, 4'b1111, 1'b1, d_rr);
    #1;
    check("midreset_valid", 32'(out_valid4), 32'd0);
    check("midreset_data", out_data4, 32'd0);
    step(1'b1, 1'b1, 0, 4'b1111, 1'b1, d_rr);
    #1;
    check("post_reset_ch", 32'(out_ch4), 32'd0);

    // Out-of-range select on the 3-channel instance.
    step(1'b1, 1'b0, 3, 4'b1111, 1'b1, d_rr);
    #1;
    check("n3_sel3_valid", 32'(out_valid3), 32'd0);

    // Sparse round-robin on the 3-channel instance: 0,2,0.
    step(1'b0, 1'b1, 0, 4'b0101, 1'b1, d_rr);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 0, 4'b0101, 1'b1, d_rr);
      #1;
      check("n3_rr_ch", 32'(out_ch3), (i == 1) ? 32'd2 : 32'd0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      d_rnd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 49) != 0), 1'($urandom), int'($urandom_range(0, 3)),
           4'($urandom), ($urandom_range(0, 3) != 0), d_rnd);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/mux_n_rr_reg.md
# mux_n_rr_reg

Parametrised, registered N-channel, W-bit selector with a valid/ready handshake on every input and on the output. It is the next generation of the 32-bit 2:1 gate-level mux. Each cycle it picks one requesting channel, either by an explicit select or by round-robin arbitration, and captures that channel's word into a one-deep output register. It sits where several producers (ALU result, memory read data, bypass paths) share a single consumer that may stall.

## Interface
Parameters:
- WIDTH, 32, data width per channel.
- NCH, 4, number of input channels (≥2).
- SELW, derived as $clog2(NCH); localparam, not overridable.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- mode  in  1  0 = explicit select (MODE_SEL), 1 = round-robin (MODE_RR).
- sel  in  SELW  channel index used in MODE_SEL; ignored in MODE_RR.
- in_data  in  NCH*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel request.
- in_ready  out  NCH  per-channel accept; at most one bit high per cycle.
- out_data  out  WIDTH  registered selected word.
- out_ch  out  SELW  index of the channel that produced out_data.
- out_valid  out  1  out_data/out_ch hold an unconsumed word.
- out_ready  in  1  consumer accepts the word this cycle.

## Operation
- load = ~out_valid | out_ready. The output register may take a new word this cycle.
- Grant in MODE_SEL: channel = sel. A grant is issued if sel < NCH and in_valid[sel]=1. If sel ≥ NCH, there is never a grant.
- Grant in MODE_RR: the first i with in_valid[i]=1, searching from ptr+1 upward and wrapping modulo NCH, ending at ptr.
- in_ready[i] = load & grant & (channel==i). This is combinational from the valid, sel, mode, out_valid and out_ready inputs and from ptr.
- Transfer (load & grant):
  - out_data <= in_data slice of the channel.
  - out_ch <= channel.
  - out_valid <= 1.
  - ptr <= channel. ptr updates in both modes, so switching to MODE_RR continues fairly from the last winner.
- load & no grant: out_valid <= 0. out_data and out_ch hold their values.
- ~load (out_valid=1, out_ready=0): all registers hold and in_ready is all zeros. out_data must not change while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=NCH-1, so channel 0 has top priority after reset. While reset_n=0, in_ready is all zeros.
- Reset asserted mid-operation discards the held word. No transfer completes in a reset cycle.
- mode and sel are sampled every cycle with no internal latching. A change takes effect in the same cycle's grant decision.

## Timing
- Latency: 1 cycle. A word accepted at edge k appears with out_valid=1 after edge k.
- Throughput: 1 word/cycle with out_ready held high, including back-to-back words from the same channel.
- Simultaneous out_ready=1 and a new grant: the old word is consumed and the new word is loaded on the same edge, with no bubble.
- Combinational paths: out_ready→in_ready and in_valid→in_ready. There is no path from any input to out_data, out_ch or out_valid.
- A producer must hold in_valid and its data stable until it sees in_ready high. The block does not depend on this for correctness.

## Structure
- Shared constants file holds MODE_SEL=1'b0 and MODE_RR=1'b1. No other shared types.
- One sub-module, rr_arbiter: a combinational block.
  - Inputs: req[NCH-1:0], ptr[SELW-1:0].
  - Outputs: gnt_valid and gnt_idx[SELW-1:0].
  - Implementation: a double-width masked priority search.
- The top level holds the mode mux, the ptr register, the output register and the in_ready decode. It is built with generate loops over NCH for the data slice select.

## Test plan
- Reset, then MODE_RR with NCH=4, WIDTH=32 and all in_valid=4'b1111, channel i data = 32'hA000_000i, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles, with out_data matching.
- MODE_SEL, sel=2, in_valid=4'b0100, data 32'hDEAD_BEEF → in_ready=4'b0100 for one cycle; the next cycle gives out_valid=1, out_data=32'hDEAD_BEEF, out_ch=2. Repeat with sel=2 and in_valid=4'b1011 → in_ready=0 and out_valid drops to 0.
- Backpressure: out_ready=0 for 3 cycles with requests pending → in_ready=0 throughout, and out_data/out_ch stay frozen. Raising out_ready → the old word is consumed and the next channel loads on the same edge.
- Mode switch: MODE_SEL grants channel 1, then switch to MODE_RR with all valid → the next grant is channel 2.
- Reset mid-stream: reset_n=0 for 1 cycle while out_valid=1 → out_valid=0 and out_data=0 next cycle. The first RR grant afterwards goes to channel 0.
- NCH=3 instance: sel=3 in MODE_SEL → no grant and in_ready=0. RR with in_valid=3'b101 → out_ch alternates 0,2,0.
